spi_reg_responder: RTL and testbench



---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 24 ++
 rtl/spi_reg_responder.sv | 161 ++++++++++++++++
 tb/tb_spi_reg_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } spi_state_e;

  localparam int CMD_WR_BIT = 7;
  localparam int SPI_BYTE_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser for an asynchronous SPI pin with rise/fall detection.
module spi_sync_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // Resetting to 0 means a CS held low through reset never shows a falling
  // edge, so the responder only wakes on a fresh CS fall.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sr <= 3'b000;
    else        sr <= {sr[1:0], pin};
  end

  assign sync = sr[1];
  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder serving a byte-addressed register file with burst auto-increment.
// Optional build macro SPI_RESP_RO_EN: RO_MASK marks registers read-only from SPI.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int                  NUM_REGS = 16,
  parameter int                  ADDR_W   = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [SPI_BYTE_W-1:0] host_wdata,
  output logic [SPI_BYTE_W-1:0] host_rdata,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [SPI_BYTE_W-1:0] wr_data,
  output logic                  frame_done,
  output logic                  busy
);

  spi_state_e state_q, state_d;

  logic sck_unused, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;

  logic [SPI_BYTE_W-1:0] regs [NUM_REGS];
  logic [2:0]            bit_cnt;
  logic [6:0]            rx_shift;
  logic [SPI_BYTE_W-1:0] rx_byte;
  logic [SPI_BYTE_W-1:0] tx_shift;
  logic [ADDR_W-1:0]     addr;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  byte_done;
  logic                  active;
  logic                  wr_ok;

  spi_sync_edge u_sck (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .pin    (spi_sck),
    .sync   (sck_unused),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_sync_edge u_cs (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .pin    (spi_cs_n),
    .sync   (cs_s),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= spi_mosi;
      mosi_s    <= mosi_meta;
    end
  end

`ifdef SPI_RESP_RO_EN
  assign wr_ok = !RO_MASK[addr];
`else
  logic ro_mask_unused;
  assign ro_mask_unused = ^RO_MASK;
  assign wr_ok          = 1'b1;
`endif

  assign rx_byte  = {rx_shift, mosi_s};
  assign cmd_addr = rx_byte[ADDR_W-1:0];
  assign active   = (state_q != IDLE) && !cs_rise;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    byte_done = sck_rise && (bit_cnt == 3'd7);
    case (state_q)
      IDLE:    if (cs_fall) state_d = CMD;
      CMD:     if (byte_done) state_d = rx_byte[CMD_WR_BIT] ? WR_DATA : RD_DATA;
      default: ;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      addr       <= '0;
      host_rdata <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_strobe  <= 1'b0;
      frame_done <= cs_rise && (state_q != IDLE);
      host_rdata <= regs[host_addr];
      // Host write first: an SPI write to the same register below overrides it.
      if (host_we) regs[host_addr] <= host_wdata;

      if ((cs_fall && state_q == IDLE) || cs_rise) begin
        bit_cnt <= '0;
      end else if (active && sck_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte[6:0];
        if (byte_done) begin
          case (state_q)
            CMD: begin
              addr <= cmd_addr;
              if (!rx_byte[CMD_WR_BIT]) begin
                tx_shift <= regs[cmd_addr];
                addr     <= cmd_addr + 1'b1;
              end
            end
            WR_DATA: begin
              if (wr_ok) begin
                regs[addr] <= rx_byte;
                wr_strobe  <= 1'b1;
                wr_addr    <= addr;
                wr_data    <= rx_byte;
              end
              addr <= addr + 1'b1;
            end
            RD_DATA: begin
              tx_shift <= regs[addr];
              addr     <= addr + 1'b1;
            end
            default: ;
          endcase
        end
      end else if (active && sck_fall && state_q == RD_DATA && bit_cnt != 3'd0) begin
        // The fall right after a byte boundary must keep the freshly loaded MSB.
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign spi_miso_oe = busy;
  assign spi_miso    = (state_q == RD_DATA) & tx_shift[7];

endmodule

// File: tb/tb_spi_reg_responder.sv
// Self-checking bench for spi_reg_responder: table-driven SPI frames plus corner-case sequences.
module tb_spi_reg_responder;

  localparam int H = 8;  // SCK half period in clk_in cycles
`ifdef SPI_RESP_RO_EN
  localparam logic [15:0] RO_MASK_TB = 16'h0001;
`else
  localparam logic [15:0] RO_MASK_TB = 16'h0000;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       spi_sck, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done, busy;

  always #5 clk_in = ~clk_in;

  spi_reg_responder #(.NUM_REGS(16), .RO_MASK(RO_MASK_TB)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [7:0] cmd; logic [7:0] b0; logic [7:0] b1;} vec_t;

  wr_t        wr_q[$];
  logic [7:0] mem [16];
  int         n_pass = 0;
  int         n_total = 0;
  int         fd_cnt = 0;
  int         fd_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Scoreboard side: pop expected SPI write commits as they appear.
  always @(negedge clk_in) begin
    if (frame_done) fd_cnt++;
    if (wr_strobe) begin
      if (wr_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: strobe addr %0h data %0h, none expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        check("wr_addr", {28'd0, wr_addr}, {28'd0, e.a});
        check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
  end

  task automatic model_spi_write(input logic [3:0] a, input logic [7:0] d);
    if (!RO_MASK_TB[a]) begin
      wr_q.push_back({a, d});
      mem[a] = d;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide,
                          input logic [3:0] h_addr, input logic [7:0] h_data,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      repeat (H) @(negedge clk_in);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      if (collide && i == 7) begin
        // Commit lands on the 3rd posedge after the pin rise.
        repeat (2) @(negedge clk_in);
        host_we = 1'b1; host_addr = h_addr; host_wdata = h_data;
        @(negedge clk_in);
        host_we = 1'b0;
        repeat (H-3) @(negedge clk_in);
      end else begin
        repeat (H) @(negedge clk_in);
      end
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low;
    spi_cs_n = 1'b0;
    repeat (H) @(negedge clk_in);
  endtask

  task automatic cs_high;
    repeat (H) @(negedge clk_in);
    spi_cs_n = 1'b1;
    repeat (2*H) @(negedge clk_in);
  endtask

  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] b0, input logic [7:0] b1);
    logic [3:0] a;
    logic [7:0] rx, exp;
    logic [7:0] data [2];
    data[0] = b0; data[1] = b1;
    a = cmd[3:0];
    cs_low();
    spi_byte(cmd, 8, 1'b0, 4'd0, 8'd0, rx);
    for (int k = 0; k < 2; k++) begin
      if (cmd[7]) begin
        model_spi_write(a, data[k]);
        spi_byte(data[k], 8, 1'b0, 4'd0, 8'd0, rx);
      end else begin
        exp = mem[a];
        spi_byte(data[k], 8, 1'b0, 4'd0, 8'd0, rx);
        check("rd_byte", {24'd0, rx}, {24'd0, exp});
      end
      a = a + 4'd1;
    end
    cs_high();
    fd_exp++;
    check("frame_done_cnt", fd_cnt, fd_exp);
  endtask

  task automatic host_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    host_addr = a;
    repeat (2) @(negedge clk_in);
    check(name, {24'd0, host_rdata}, {24'd0, exp});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[7];
    logic [7:0] rx;

    vecs[0] = '{8'h80, 8'h81, 8'h03};
    vecs[1] = '{8'h00, 8'hFF, 8'hFF};
    vecs[2] = '{8'h8F, 8'hAA, 8'hBB};
    vecs[3] = '{8'h0F, 8'h00, 8'h00};
    vecs[4] = '{8'h70, 8'h5A, 8'hA5};  // upper command address bits ignored
    vecs[5] = '{8'h85, 8'h12, 8'h34};
    vecs[6] = '{8'h05, 8'hFF, 8'h00};

    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'd0;
    repeat (3) @(negedge clk_in);
    check("rst_miso", {31'd0, spi_miso}, 0);
    check("rst_oe", {31'd0, spi_miso_oe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    check("rst_host_rdata", {24'd0, host_rdata}, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_in);
    check("post_rst_frame_done", fd_cnt, 0);
    check("post_rst_busy", {31'd0, busy}, 0);

    for (int v = 0; v < 7; v++) spi_frame(vecs[v].cmd, vecs[v].b0, vecs[v].b1);

    host_check("reg15_wrap", 4'd15, 8'hAA);
    host_check("reg1", 4'd1, 8'h03);
    host_check("reg0_wrap", 4'd0, RO_MASK_TB[0] ? 8'h00 : 8'hBB);
    host_check("reg5", 4'd5, 8'h12);

    // Same-register collision: SPI write wins.
    cs_low();
    spi_byte(8'h82, 8, 1'b0, 4'd0, 8'd0, rx);
    model_spi_write(4'd2, 8'h66);
    spi_byte(8'h66, 8, 1'b1, 4'd2, 8'h55, rx);
    cs_high(); fd_exp++;
    host_check("collide_same", 4'd2, 8'h66);

    // Different-register collision: both commit.
    cs_low();
    spi_byte(8'h83, 8, 1'b0, 4'd0, 8'd0, rx);
    model_spi_write(4'd3, 8'h77);
    mem[4] = 8'h99;
    spi_byte(8'h77, 8, 1'b1, 4'd4, 8'h99, rx);
    cs_high(); fd_exp++;
    host_check("collide_diff_spi", 4'd3, 8'h77);
    host_check("collide_diff_host", 4'd4, 8'h99);

    // Abort after 5 bits of a data byte.
    cs_low();
    spi_byte(8'h82, 8, 1'b0, 4'd0, 8'd0, rx);
    spi_byte(8'hFF, 5, 1'b0, 4'd0, 8'd0, rx);
    cs_high(); fd_exp++;
    check("abort_frame_done", fd_cnt, fd_exp);
    host_check("abort_reg2", 4'd2, 8'h66);
    spi_frame(8'h82, 8'h44, 8'h45);
    host_check("after_abort_reg2", 4'd2, 8'h44);

    // Reset in the middle of a read burst.
    cs_low();
    spi_byte(8'h00, 8, 1'b0, 4'd0, 8'd0, rx);
    spi_byte(8'hFF, 3, 1'b0, 4'd0, 8'd0, rx);
    @(negedge clk_in); rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    check("midrst_oe", {31'd0, spi_miso_oe}, 0);
    check("midrst_miso", {31'd0, spi_miso}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) host_check("midrst_reg", 4'(i), 8'h00);
    spi_byte(8'hFF, 5, 1'b0, 4'd0, 8'd0, rx);
    spi_byte(8'h85, 8, 1'b0, 4'd0, 8'd0, rx);
    spi_byte(8'h11, 8, 1'b0, 4'd0, 8'd0, rx);
    check("midrst_ignored_busy", {31'd0, busy}, 0);
    cs_high();
    check("midrst_no_frame_done", fd_cnt, fd_exp);
    host_check("midrst_reg5", 4'd5, 8'h00);
    spi_frame(8'h81, 8'h5A, 8'hC3);
    host_check("fresh_frame_reg1", 4'd1, 8'h5A);

    // Write to reg0 then reg1; reg0 is read-only when the RO feature is built in.
    spi_frame(8'h80, 8'h7F, 8'h21);
    host_check("ro_reg0", 4'd0, RO_MASK_TB[0] ? 8'h00 : 8'h7F);
    host_check("ro_reg1", 4'd1, 8'h21);

    repeat (4) @(negedge clk_in);
    check("strobe_queue_drained", wr_q.size(), 0);
    check("frame_done_total", fd_cnt, fd_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
